// File: rtl/seq_mul_add8.sv
// -----------------------------------------------------------------------------
// seq_mul_add8
//   Sequential shift-add multiply-accumulate computing P = Q*B + R.
//   This is the reconstruction path beside the array divider. It rebuilds a
//   dividend from a quotient, a divisor and a remainder. It uses one
//   2*WIDTH-bit adder row that it iterates WIDTH times. Each operation takes
//   WIDTH+2 cycles from accept to the next accept.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   start    in   request, sampled only while ready=1
//   Q        in   multiplier (quotient), unsigned, WIDTH bits
//   B        in   multiplicand (divisor), unsigned, WIDTH bits
//   R        in   addend (remainder), unsigned, WIDTH bits
//   ready    out  1 while idle and able to accept start
//   done     out  one-cycle pulse, P/rem_err just updated
//   P        out  Q*B+R, 2*WIDTH bits, held until the next done
//   rem_err  out  1 when the latched R >= B with B != 0, valid with P
// -----------------------------------------------------------------------------
module seq_mul_add8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   R,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output logic               rem_err
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mq;         // multiplier, consumed LSB first
  logic [2*WIDTH-1:0]   mb;         // multiplicand, shifted left each step
  logic [2*WIDTH-1:0]   acc;        // running sum, seeded with R
  logic [CNT_W-1:0]     cnt;
  logic                 rem_err_n;  // remainder check, published with P

  // The product plus a WIDTH-bit addend never exceeds 2^(2*WIDTH)-1.
  // No carry-out is needed.
  logic [2*WIDTH-1:0]   acc_next;
  assign acc_next = mq[0] ? acc + mb : acc;

  // NOTE: every register in this block uses non-blocking assignments.
  // Each branch then reads the pre-edge values of mq/mb/acc. This matches
  // the shift-add recurrence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      P         <= '0;
      rem_err   <= 1'b0;
      mq        <= '0;
      mb        <= '0;
      acc       <= '0;
      cnt       <= '0;
      rem_err_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mq        <= Q;
            mb        <= {{WIDTH{1'b0}}, B};
            acc       <= {{WIDTH{1'b0}}, R};
            cnt       <= '0;
            rem_err_n <= (B != '0) && (R >= B);
            ready     <= 1'b0;
            state     <= RUN;
          end
        end

        RUN: begin
          acc <= acc_next;
          mb  <= mb << 1;
          mq  <= mq >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // The last step publishes the sum that includes this step's
            // partial product.
            P       <= acc_next;
            rem_err <= rem_err_n;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_add8.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_add8
//   Self-checking bench for seq_mul_add8. The expected results come from
//   plain integer arithmetic:
//     P       = Q*B + R
//     rem_err = (B != 0) && (R >= B)
//   Timing follows the transaction contract. done goes high WIDTH+1 sampled
//   cycles after the accepting edge. Accepts are spaced WIDTH+2 cycles apart.
// -----------------------------------------------------------------------------
module tb_seq_mul_add8;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   q_in;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH-1:0]   r_in;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] p_out;
  logic               rem_err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul_add8 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .Q       (q_in),
    .B       (b_in),
    .R       (r_in),
    .ready   (ready),
    .done    (done),
    .P       (p_out),
    .rem_err (rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_p(input int q, input int b, input int r);
    return 32'(q * b + r);
  endfunction

  function automatic logic [31:0] model_err(input int b, input int r);
    return {31'b0, (b != 0) && (r >= b)};
  endfunction

  // Waits, on falling edges, until the DUT reports ready. The wait is bounded.
  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Runs one transaction and checks the result, latency and hold behaviour.
  // With scramble set, the task changes the operands and pulses start while
  // the DUT is busy. The result must still match the accepted set.
  task automatic do_op(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] r, input bit scramble,
                       input logic [31:0] exp_p, input string tag);
    int               cycles;
    bit               busy_ok;
    bit               hold_ok;
    logic [2*WIDTH-1:0] p_prev;
    logic             e_prev;
    wait_ready();
    p_prev = p_out;
    e_prev = rem_err;
    start  = 1'b1;
    q_in   = q;
    b_in   = b;
    r_in   = r;
    @(posedge clk);                 // accepting edge
    cycles  = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
      if (scramble) begin
        q_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        r_in  = WIDTH'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (done !== 1'b1 && (p_out !== p_prev || rem_err !== e_prev)) hold_ok = 1'b0;
    end while (done !== 1'b1 && cycles < 40);
    start = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'(WIDTH + 1));
    check({tag, "_P"}, 32'(p_out), exp_p);
    check({tag, "_rem_err"}, 32'(rem_err), model_err(int'(b), int'(r)));
    check({tag, "_busy_ready"}, 32'(busy_ok), 32'd1);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int done_at[$];
    int n_done;
    logic [WIDTH-1:0] q, b, r;
    int a;

    rst   = 1'b1;
    start = 1'b0;
    q_in  = '0;
    b_in  = '0;
    r_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_P", 32'(p_out), 32'd0);
    check("rst_rem_err", 32'(rem_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op(8'h0D, 8'h13, 8'h05, 1'b0, model_p(13, 19, 5), "dir_basic");
    do_op(8'hFF, 8'hFF, 8'hFF, 1'b0, 32'h0000FF00, "dir_max");
    do_op(8'hAA, 8'h00, 8'h07, 1'b0, 32'h00000007, "dir_b0");
    do_op(8'h00, 8'h35, 8'h21, 1'b0, 32'h00000021, "dir_q0");
    do_op(8'h5A, 8'hC3, 8'h10, 1'b1, model_p(8'h5A, 8'hC3, 8'h10), "dir_scramble");

    // Back-to-back: start is held high and the operands stay constant.
    wait_ready();
    q_in  = 8'h37;
    b_in  = 8'h29;
    r_in  = 8'h2A;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("b2b_ready", 32'(ready), 32'((i % (WIDTH + 2)) == (WIDTH + 1)));
      if (done === 1'b1) begin
        done_at.push_back(i);
        check("b2b_P", 32'(p_out), model_p(8'h37, 8'h29, 8'h2A));
        check("b2b_rem_err", 32'(rem_err), 32'd1);
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(done_at.size()), 32'd4);
    if (done_at.size() > 0) check("b2b_first", 32'(done_at[0]), 32'(WIDTH));
    for (int i = 1; i < done_at.size(); i++)
      check("b2b_spacing", 32'(done_at[i] - done_at[i-1]), 32'(WIDTH + 2));
    wait_ready();

    // Abort in mid-operation with reset when cnt is 3.
    check("pre_abort_P_nonzero", 32'(p_out != '0), 32'd1);
    start = 1'b1;
    q_in  = 8'hE1;
    b_in  = 8'h77;
    r_in  = 8'h03;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_P", 32'(p_out), 32'd0);
    check("abort_rem_err", 32'(rem_err), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_idle", 32'(ready), 32'd1);

    // Random operations, some of them with busy-time scrambling.
    for (int i = 0; i < 1500; i++) begin
      q = WIDTH'($urandom);
      b = WIDTH'($urandom);
      r = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      do_op(q, b, r, 1'($urandom_range(0, 1)),
            model_p(int'(q), int'(b), int'(r)), "rand");
    end

    // Round trip with the divider: for A and B != 0, Q*B + A%B must rebuild A.
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(1, 255));
      q = WIDTH'(a / int'(b));
      r = WIDTH'(a % int'(b));
      do_op(q, b, r, 1'b0, 32'(a), "roundtrip");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
